sci_frame_ctrl: RTL and testbench

Frame controller for the serial configuration interface (SCI) slave. It decodes a CSN-framed serial stream of command bit, address and data, LSB first. It sequences an external SIPO_BUFFER of depth DATA_WIDTH through SIPO_EN and captures the SIPO's parallel output. It issues register-file write strobes and read requests, and shifts read data back out on SOUT.

---
 rtl/sci_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sci_frame_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sci_frame_ctrl.sv
// SCI slave frame controller: decodes a CSN-framed, LSB-first command/address/data
// stream, sequences the external SIPO, and issues register write strobes and read requests.
module sci_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  csn_i,
    input  logic                  sin_i,
    output logic                  sipo_en_o,
    input  logic [DATA_WIDTH-1:0] sipo_pout_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wreq_o,
    output logic                  rreq_o,
    input  logic                  rack_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  sout_o,
    output logic                  sout_oe_o,
    output logic                  busy_o,
    output logic                  abort_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    // CMD carries the first address bit; RD_CAP is the read-path cycle in which
    // the address is taken from the SIPO before the request is raised.
    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_WSTB,
        S_RD_CAP,
        S_RD_REQ,
        S_RD_SHIFT,
        S_WAIT_END
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  cmd_wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  wreq_q;
    logic                  rreq_q;
    logic                  oe_q;
    logic                  abort_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cmd_wr_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shift_q  <= '0;
            wreq_q   <= 1'b0;
            rreq_q   <= 1'b0;
            oe_q     <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            wreq_q  <= 1'b0;
            abort_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!csn_i) begin
                        cmd_wr_q <= sin_i;
                        cnt_q    <= '0;
                        state_q  <= S_CMD;
                    end
                end
                S_CMD, S_ADDR: begin
                    if (csn_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        abort_q <= 1'b1;
                    end else if (cnt_q == ADDR_LAST) begin
                        cnt_q   <= '0;
                        state_q <= cmd_wr_q ? S_WDATA : S_RD_CAP;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= S_ADDR;
                    end
                end
                S_WDATA: begin
                    if (csn_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        abort_q <= 1'b1;
                    end else begin
                        // Address is still intact in the SIPO top bits during the first data cycle.
                        if (cnt_q == '0) begin
                            addr_q <= sipo_pout_i[DATA_WIDTH-1 -: ADDR_WIDTH];
                        end
                        if (cnt_q == DATA_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_WSTB;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_WSTB: begin
                    wdata_q <= sipo_pout_i;
                    wreq_q  <= 1'b1;
                    state_q <= S_WAIT_END;
                end
                S_RD_CAP: begin
                    if (csn_i) begin
                        state_q <= S_IDLE;
                        abort_q <= 1'b1;
                    end else begin
                        addr_q  <= sipo_pout_i[DATA_WIDTH-1 -: ADDR_WIDTH];
                        rreq_q  <= 1'b1;
                        state_q <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (csn_i) begin
                        rreq_q  <= 1'b0;
                        state_q <= S_IDLE;
                        abort_q <= 1'b1;
                    end else if (rreq_q && rack_i) begin
                        shift_q <= rdata_i;
                        rreq_q  <= 1'b0;
                        oe_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_RD_SHIFT;
                    end
                end
                S_RD_SHIFT: begin
                    if (csn_i) begin
                        oe_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        abort_q <= 1'b1;
                    end else begin
                        shift_q <= shift_q >> 1;
                        if (cnt_q == DATA_LAST) begin
                            oe_q    <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= S_WAIT_END;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_WAIT_END: begin
                    if (csn_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign sipo_en_o = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign wreq_o    = wreq_q;
    assign rreq_o    = rreq_q;
    assign sout_o    = oe_q & shift_q[0];
    assign sout_oe_o = oe_q;
    assign busy_o    = (state_q != S_IDLE);
    assign abort_o   = abort_q;

endmodule

// File: tb/tb_sci_frame_ctrl.sv
// Bench for sci_frame_ctrl: table of write/read frames with a SIPO model and
// scoreboard queues, plus hand-written abort, reset and corner sequences.
module tb_sci_frame_ctrl;

    localparam int D = 8;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         csn;
    logic         sin;
    logic         sipo_en;
    logic [D-1:0] sipo_pout = '0;
    logic [A-1:0] addr;
    logic [D-1:0] wdata;
    logic         wreq;
    logic         rreq;
    logic         rack;
    logic [D-1:0] rdata;
    logic         sout;
    logic         sout_oe;
    logic         busy;
    logic         abort;

    sci_frame_ctrl #(.DATA_WIDTH(D), .ADDR_WIDTH(A)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .csn_i      (csn),
        .sin_i      (sin),
        .sipo_en_o  (sipo_en),
        .sipo_pout_i(sipo_pout),
        .addr_o     (addr),
        .wdata_o    (wdata),
        .wreq_o     (wreq),
        .rreq_o     (rreq),
        .rack_i     (rack),
        .rdata_i    (rdata),
        .sout_o     (sout),
        .sout_oe_o  (sout_oe),
        .busy_o     (busy),
        .abort_o    (abort)
    );

    always #5 clk = ~clk;

    // External SIPO: new bit enters at the MSB, shifting toward the LSB.
    always_ff @(posedge clk) begin
        if (sipo_en) sipo_pout <= {sin, sipo_pout[D-1:1]};
    end

    typedef struct {
        logic         wr;
        logic [A-1:0] a;
        logic [D-1:0] d;
        int           wait_n;
        int           extra;
        int           gap;
        logic [D-1:0] exp_word;
        int           exp_sipo;
        int           exp_rel;
    } vec_t;

    typedef struct {
        logic [A-1:0] a;
        logic [D-1:0] d;
    } wr_t;

    wr_t          wr_q[$];
    logic [D-1:0] rd_q[$];

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;
    int fstart = 0;
    int n_wreq, wreq_rel, n_sipo, last_sipo, n_rreq, rreq_first, n_oe, n_abort, nbits;
    logic [D-1:0] sbits;
    logic [D-1:0] last_wd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc_no);
        end
    endtask

    task automatic clear_counts();
        n_wreq = 0; wreq_rel = -1; n_sipo = 0; last_sipo = -1;
        n_rreq = 0; rreq_first = -1; n_oe = 0; n_abort = 0;
    endtask

    task automatic observe();
        wr_t w;
        if (wreq) begin
            n_wreq++;
            wreq_rel = cyc_no - fstart;
            check("wreq_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("wr_addr", 32'(addr), 32'(w.a));
                check("wr_data", 32'(wdata), 32'(w.d));
            end
        end
        if (sout_oe) begin
            n_oe++;
            sbits = {sout, sbits[D-1:1]};
            nbits++;
            if (nbits == D) begin
                nbits = 0;
                check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) check("sout_word", 32'(sbits), 32'(rd_q.pop_front()));
            end
        end
        if (sipo_en) begin
            n_sipo++;
            last_sipo = cyc_no - fstart;
        end
        if (rreq) begin
            if (rreq_first < 0) rreq_first = cyc_no - fstart;
            n_rreq++;
        end
        if (abort) n_abort++;
    endtask

    // Drive one cycle's inputs just after the rising edge, observe at the falling edge.
    task automatic cyc(input logic c, input logic s);
        csn = c;
        sin = s;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic run_frame(input vec_t v);
        fstart = cyc_no;
        clear_counts();
        if (v.wr) wr_q.push_back('{v.a, v.exp_word});
        else      rd_q.push_back(v.exp_word);
        cyc(1'b0, v.wr);
        for (int i = 0; i < A; i++) cyc(1'b0, v.a[i]);
        if (v.wr) begin
            for (int i = 0; i < D; i++) cyc(1'b0, v.d[i]);
        end else begin
            rack = 1'b1; rdata = ~v.d;          // acknowledge before any request must be ignored
            cyc(1'b0, 1'b1);
            rack = 1'b0;
            for (int i = 0; i < v.wait_n; i++) cyc(1'b0, 1'b1);
            rack = 1'b1; rdata = v.d;
            cyc(1'b0, 1'b0);
            rack = 1'b0; rdata = D'($urandom);
            for (int i = 0; i < D; i++) cyc(1'b0, 1'b1);
        end
        for (int i = 0; i < v.extra; i++) cyc(1'b0, 1'b1);
        for (int i = 0; i < v.gap; i++) cyc(1'b1, 1'b0);
    endtask

    task automatic check_frame(input vec_t v, input string tag);
        check({tag, "_sipo_cnt"}, 32'(n_sipo), 32'(v.exp_sipo));
        check({tag, "_sipo_last"}, 32'(last_sipo), 32'(v.exp_sipo));
        check({tag, "_event_cycle"}, 32'(v.wr ? wreq_rel : rreq_first), 32'(v.exp_rel));
        check({tag, "_wreq_cnt"}, 32'(n_wreq), 32'(v.wr ? 1 : 0));
        check({tag, "_rreq_cnt"}, 32'(n_rreq), 32'(v.wr ? 0 : v.wait_n + 1));
        check({tag, "_oe_cnt"}, 32'(n_oe), 32'(v.wr ? 0 : D));
        check({tag, "_abort_cnt"}, 32'(n_abort), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        if (!v.wr) check({tag, "_rd_addr"}, 32'(addr), 32'(v.a));
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin
        vecs[0] = '{1'b1, 4'hA, 8'h5C, 0, 0, 2, 8'h5C, A + D, A + D + 2};
        vecs[1] = '{1'b0, 4'h3, 8'hB1, 3, 0, 1, 8'hB1, A, A + 2};
        vecs[2] = '{1'b1, 4'hF, 8'hFF, 0, 5, 1, 8'hFF, A + D, A + D + 2};
        vecs[3] = '{1'b1, 4'h1, 8'h80, 0, 1, 1, 8'h80, A + D, A + D + 2};
        vecs[4] = '{1'b1, 4'h2, 8'h01, 0, 2, 1, 8'h01, A + D, A + D + 2};
        vecs[5] = '{1'b0, 4'hC, 8'h00, 0, 2, 1, 8'h00, A, A + 2};
        vecs[6] = '{1'b0, 4'h8, 8'h7E, 1, 0, 1, 8'h7E, A, A + 2};
        vecs[7] = '{1'b1, 4'h0, 8'h00, 0, 1, 2, 8'h00, A + D, A + D + 2};

        rst = 1'b1; csn = 1'b1; sin = 1'b0; rack = 1'b0; rdata = '0;
        nbits = 0; sbits = '0; last_wd = '0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({sipo_en, addr, wdata, wreq, rreq, sout, sout_oe, busy, abort}), 32'd0);
        rst = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i]);
            check_frame(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].wr) last_wd = vecs[i].exp_word;
            $display("vec %0d: %s addr=%0h word=%0h total=%0d bad=%0d", i,
                     vecs[i].wr ? "write" : "read", vecs[i].a, vecs[i].exp_word, total, bad);
        end

        // Write aborted after two data bits: no strobe, address updated, data kept.
        fstart = cyc_no; clear_counts();
        cyc(1'b0, 1'b1);
        for (int i = 0; i < A; i++) cyc(1'b0, i[0]);   // address 4'h6? bits 0,1,0,1 -> 4'hA
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check("wabort_pulse_now", 32'(n_abort), 32'd1);
        cyc(1'b1, 1'b0);
        check("wabort_pulse_width", 32'(n_abort), 32'd1);
        check("wabort_no_wreq", 32'(n_wreq), 32'd0);
        check("wabort_addr", 32'(addr), 32'hA);
        check("wabort_wdata_kept", 32'(wdata), 32'(last_wd));
        check("wabort_busy", 32'(busy), 32'd0);
        $display("write abort: total=%0d bad=%0d", total, bad);

        // Read aborted while waiting for acknowledge.
        fstart = cyc_no; clear_counts();
        cyc(1'b0, 1'b0);
        for (int i = 0; i < A; i++) cyc(1'b0, (i == 0) || (i == 3));   // address 4'h9
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check("rabort_rreq_dropped", 32'(rreq), 32'd0);
        check("rabort_pulse", 32'(n_abort), 32'd1);
        check("rabort_rreq_cycles", 32'(n_rreq), 32'd3);
        check("rabort_no_oe", 32'(n_oe), 32'd0);
        check("rabort_addr", 32'(addr), 32'h9);
        check("rabort_busy", 32'(busy), 32'd0);
        $display("read abort: total=%0d bad=%0d", total, bad);

        // Abort right after the command bit leaves ADDR untouched.
        fstart = cyc_no; clear_counts();
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        check("cabort_pulse", 32'(n_abort), 32'd1);
        check("cabort_addr_kept", 32'(addr), 32'h9);
        check("cabort_no_wreq", 32'(n_wreq), 32'd0);
        $display("cmd abort: total=%0d bad=%0d", total, bad);

        // Reset in the middle of read data shifting.
        fstart = cyc_no; clear_counts();
        rd_q.push_back(8'hA5);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < A; i++) cyc(1'b0, i == 2);   // address 4'h4
        cyc(1'b0, 1'b0);
        rack = 1'b1; rdata = 8'hA5;
        cyc(1'b0, 1'b0);
        rack = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("rst_mid_oe_before", 32'(sout_oe), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 32'({sipo_en, addr, wdata, wreq, rreq, sout, sout_oe, busy, abort}), 32'd0);
        rd_q.delete();
        nbits = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        csn = 1'b1;
        cyc(1'b1, 1'b0);
        v = '{1'b1, 4'h7, 8'h3C, 0, 0, 2, 8'h3C, A + D, A + D + 2};
        run_frame(v);
        check_frame(v, "post_rst");
        $display("reset mid-read then write: total=%0d bad=%0d", total, bad);

        check("queues_drained", 32'(wr_q.size() + rd_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
